// File: rtl/seq_regfile_writeback_if.sv
// Completion bundle from execute/memory into the SEQ write-back stage.
// The master drives one completing instruction per step; the slave commits it.
interface seq_regfile_writeback_if;
    logic        step;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        imem_error;
    logic        instr_invalid;
    logic        dmem_error;

    modport master (
        output step, icode, rA, rB, cnd, valE, valM,
        output imem_error, instr_invalid, dmem_error
    );

    modport slave (
        input step, icode, rA, rB, cnd, valE, valM,
        input imem_error, instr_invalid, dmem_error
    );
endinterface

// File: rtl/seq_regfile_writeback.sv
// SEQ Y86-64 architectural state: register file, status and retired count.
// A fault or halt freezes everything until reset.
module seq_regfile_writeback #(
    parameter int          CNT_W    = 32,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_regfile_writeback_if.slave bus,
    output logic [63:0]          rax,
    output logic [63:0]          rcx,
    output logic [63:0]          rdx,
    output logic [63:0]          rbx,
    output logic [63:0]          rsp,
    output logic [63:0]          rbp,
    output logic [63:0]          rsi,
    output logic [63:0]          rdi,
    output logic [63:0]          r8,
    output logic [63:0]          r9,
    output logic [63:0]          r10,
    output logic [63:0]          r11,
    output logic [63:0]          r12,
    output logic [63:0]          r13,
    output logic [63:0]          r14,
    output logic [1:0]           stat,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired
);

    localparam logic [1:0] AOK = 2'd0;
    localparam logic [1:0] HLT = 2'd1;
    localparam logic [1:0] ADR = 2'd2;
    localparam logic [1:0] INS = 2'd3;
    localparam logic [3:0] RNONE = 4'hF;

    logic [63:0] regs [0:14];
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        live;
    logic        fault;
    logic        commit;

    always_comb begin
        dst_e = RNONE;
        unique case (bus.icode)
            4'h2:    dst_e = bus.cnd ? bus.rB : RNONE;
            4'h3,
            4'h6:    dst_e = bus.rB;
            4'h8,
            4'h9,
            4'hA,
            4'hB:    dst_e = 4'd4;
            default: dst_e = RNONE;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        if (bus.icode == 4'h5 || bus.icode == 4'hB)
            dst_m = bus.rA;
    end

    assign live   = bus.step && (stat == AOK);
    assign fault  = bus.imem_error || bus.instr_invalid || bus.dmem_error;
    assign commit = live && !fault;

    // valM is checked first so it wins when both ports name the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (commit && dst_m == 4'(i))
                    regs[i] <= bus.valM;
                else if (commit && dst_e == 4'(i))
                    regs[i] <= bus.valE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat <= AOK;
        end else if (live) begin
            if (bus.imem_error)
                stat <= ADR;
            else if (bus.instr_invalid)
                stat <= INS;
            else if (bus.dmem_error)
                stat <= ADR;
            else if (bus.icode == 4'h0)
                stat <= HLT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired <= '0;
        else if (commit && retired != '1)
            retired <= retired + 1'b1;
    end

    assign halted = (stat != AOK);

    assign rax = regs[0];
    assign rcx = regs[1];
    assign rdx = regs[2];
    assign rbx = regs[3];
    assign rsp = regs[4];
    assign rbp = regs[5];
    assign rsi = regs[6];
    assign rdi = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];

endmodule
